// File: rtl/fcc_point_scanner.sv
// fcc_point_scanner: raster-scans fcc_point_memory and streams (row, col, label) entries.
// Latency: first out_valid 3 edges after the start sampling edge; 1 entry/cycle sustained.
// Backpressure: out_ready low fills a 2-entry buffer and then stalls address issue; nothing is lost or duplicated.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, skip_ground       scan request pulse; ground-drop mode sampled with start
//   busy, done, point_count  scan status, completion pulse, handshake count of the current/last scan
//   rd_row, rd_col           registered read address to the memory
//   rd_label, rd_is_ground   memory read data, valid one cycle after the address
//   out_valid/out_ready      output stream handshake
//   out_row/out_col/out_label  head entry of the output buffer

// Small first-word-fall-through FIFO; head_dat shows the oldest entry.
// Latency: an entry pushed at an edge is visible on head_dat right after that edge.
// Backpressure: the caller must not push when full unless it pops in the same cycle.
module fcc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop   = pop_rdy && (count != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module fcc_point_scanner #(
    parameter int ROWS    = 30,
    parameter int COLS    = 30,
    parameter int ROW_W   = 8,
    parameter int COL_W   = 5,
    parameter int LABEL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               skip_ground,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   point_count,
    output logic [ROW_W-1:0]   rd_row,
    output logic [COL_W-1:0]   rd_col,
    input  logic [LABEL_W-1:0] rd_label,
    input  logic               rd_is_ground,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROW_W-1:0]   out_row,
    output logic [COL_W-1:0]   out_col,
    output logic [LABEL_W-1:0] out_label
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [LABEL_W-1:0] label;
    } ent_t;

    state_t             state_q;
    state_t             state_d;
    logic               done_q;
    logic               skip_q;
    logic [ROW_W-1:0]   nxt_row;
    logic [COL_W-1:0]   nxt_col;
    logic               addr_vld;   // rd_row/rd_col were issued at the last edge
    logic               inflight;   // rd_label currently holds data for tag_row/tag_col
    logic [ROW_W-1:0]   tag_row;
    logic [COL_W-1:0]   tag_col;
    logic [1:0]         buf_count;
    ent_t               head;
    ent_t               push_ent;
    logic               pop;
    logic               push;
    logic               discard;
    logic               consumed;
    logic [2:0]         occ;
    logic               issue_ok;
    logic               issue;
    logic               start_acc;
    logic               last_cell;
    logic               drain_empty;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign pop       = out_valid && out_ready;
    assign out_valid = (buf_count != 2'd0);
    assign out_row   = head.row;
    assign out_col   = head.col;
    assign out_label = head.label;

    // Only the data-stage entry is charged against buffer space. An entry
    // that was just issued is safe because issue is refused whenever the
    // buffer could still be full when that entry reaches the data stage.
    assign occ      = 3'(buf_count) + 3'(inflight) - 3'(pop);
    assign issue_ok = (occ < 3'd2);

    assign discard  = skip_q && rd_is_ground;
    assign push     = inflight && !discard && ((buf_count != 2'd2) || pop);
    assign consumed = inflight && (discard || push);

    assign push_ent.row   = tag_row;
    assign push_ent.col   = tag_col;
    assign push_ent.label = rd_label;

    assign last_cell   = (nxt_row == ROW_W'(ROWS - 1)) && (nxt_col == COL_W'(COLS - 1));
    assign drain_empty = !addr_vld && !inflight && (buf_count == 2'd0);
    assign done        = done_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (issue && last_cell) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        issue     = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                start_acc = start && !done_q;
            end
            ST_SCAN: begin
                busy  = 1'b1;
                issue = issue_ok;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation, read pipeline and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q      <= 1'b0;
            skip_q      <= 1'b0;
            nxt_row     <= '0;
            nxt_col     <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            addr_vld    <= 1'b0;
            inflight    <= 1'b0;
            tag_row     <= '0;
            tag_col     <= '0;
            point_count <= '0;
        end else begin
            done_q <= (state_q == ST_DRAIN) && drain_empty;

            if (start_acc) begin
                skip_q      <= skip_ground;
                nxt_row     <= '0;
                nxt_col     <= '0;
                point_count <= '0;
            end else if (pop && (point_count != {CNT_W{1'b1}})) begin
                point_count <= point_count + CNT_W'(1);
            end

            if (issue) begin
                rd_row <= nxt_row;
                rd_col <= nxt_col;
                if (nxt_col == COL_W'(COLS - 1)) begin
                    nxt_col <= '0;
                    nxt_row <= nxt_row + ROW_W'(1);
                end else begin
                    nxt_col <= nxt_col + COL_W'(1);
                end
            end

            addr_vld <= issue;

            if (addr_vld) begin
                tag_row <= rd_row;
                tag_col <= rd_col;
            end

            // A data-stage entry that cannot be captured simply stays put:
            // no newer address was issued behind it, so rd_row/rd_col still
            // point at it and the memory re-presents the same data.
            inflight <= addr_vld || (inflight && !consumed);
        end
    end

    fcc_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (2)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_ent),
        .pop_rdy  (pop),
        .head_dat (head),
        .count    (buf_count)
    );
endmodule

// File: tb/tb_fcc_point_scanner.sv
module tb_fcc_point_scanner;
    localparam int ROWS    = 3;
    localparam int COLS    = 4;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 5;
    localparam int LABEL_W = 16;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               skip_ground = 1'b0;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   point_count;
    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [LABEL_W-1:0] rd_label = '0;
    logic               rd_is_ground = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [ROW_W-1:0]   out_row;
    logic [COL_W-1:0]   out_col;
    logic [LABEL_W-1:0] out_label;

    fcc_point_scanner #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .LABEL_W(LABEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .skip_ground(skip_ground),
        .busy(busy), .done(done), .point_count(point_count),
        .rd_row(rd_row), .rd_col(rd_col), .rd_label(rd_label),
        .rd_is_ground(rd_is_ground), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_label(out_label)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int l;
    } exp_t;

    exp_t exp_q[$];
    int   lbl [ROWS][COLS];
    bit   gnd [ROWS][COLS];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   exp_n = 0;
    int   pc_model = 0;
    int   hs_total = 0;
    int   hs_cyc[$];
    int   valid_cycles = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory with a one-cycle registered read port.
    always @(posedge clk) begin
        if (int'(rd_row) < ROWS && int'(rd_col) < COLS) begin
            rd_label     <= LABEL_W'(lbl[int'(rd_row)][int'(rd_col)]);
            rd_is_ground <= gnd[int'(rd_row)][int'(rd_col)];
        end else begin
            rd_label     <= '0;
            rd_is_ground <= 1'b0;
        end
    end

    always @(posedge clk) cyc++;

    // Downstream: always ready, or a 50% random ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom % 2);
        end
    end

    // Compare process: every cycle against the expected-entry queue.
    initial begin
        bit prev_stall = 0;
        bit prev_done  = 0;
        int p_row = 0, p_col = 0, p_lbl = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
                prev_done  = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_row", out_row, p_row);
                    chk("hold_col", out_col, p_col);
                    chk("hold_label", out_label, p_lbl);
                end
                if (busy) chk("live_point_count", point_count, pc_model);
                if (out_valid) begin
                    valid_cycles++;
                    chk("busy_with_valid", busy, 1);
                end
                if (out_valid && out_ready) begin
                    chk("entry_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        chk("entry_row", out_row, exp_q[0].r);
                        chk("entry_col", out_col, exp_q[0].c);
                        chk("entry_label", out_label, exp_q[0].l);
                        void'(exp_q.pop_front());
                    end
                    hs_total++;
                    hs_cyc.push_back(cyc);
                    pc_model++;
                end
                if (done) begin
                    chk("done_single_cycle", prev_done, 0);
                    chk("done_queue_empty", exp_q.size(), 0);
                    chk("done_point_count", point_count, exp_n);
                    chk("done_busy_low", busy, 0);
                    done_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                p_row = int'(out_row);
                p_col = int'(out_col);
                p_lbl = int'(out_label);
                prev_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic grid_plain();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                lbl[r][c] = 10 * r + c;
                gnd[r][c] = 1'b0;
            end
    endtask

    task automatic grid_three_ground();
        grid_plain();
        gnd[0][1] = 1'b1;
        gnd[1][2] = 1'b1;
        gnd[2][3] = 1'b1;
    endtask

    // Reference: raster order, minus ground cells when skipping.
    task automatic build(input bit skip);
        exp_t e;
        exp_q.delete();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!(skip && gnd[r][c])) begin
                    e.r = r; e.c = c; e.l = lbl[r][c];
                    exp_q.push_back(e);
                end
        exp_n = exp_q.size();
    endtask

    task automatic start_scan(input bit skip);
        build(skip);
        @(posedge clk);
        #1;
        start = 1'b1;
        skip_ground = skip;
        @(posedge clk);
        #1;
        start = 1'b0;
        pc_model = 0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n >= max) begin
                checks++;
                failures++;
                $display("FAIL done_timeout waited=%0d cycles limit=%0d", n, max);
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_point_count"}, point_count, 0);
        chk({tag, "_rd_row"}, rd_row, 0);
        chk({tag, "_rd_col"}, rd_col, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_out_col"}, out_col, 0);
        chk({tag, "_out_label"}, out_label, 0);
    endtask

    initial begin
        int n, hs0, dc0, vc0;
        bit skip;

        grid_plain();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Plain grid, always ready: latency, order, back-to-back output.
        ready_mode = 0;
        hs0 = hs_total; dc0 = done_cnt;
        start_scan(0);
        @(negedge clk);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_valid_edge0", out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("t1_valid_edge2", out_valid, 0);
        @(negedge clk);
        chk("t1_valid_edge3", out_valid, 1);
        chk("t1_first_label", out_label, 0);
        chk("t1_first_col", out_col, 0);
        wait_done(100, n);
        chk("t1_point_count", point_count, 12);
        chk("t1_entries", hs_total - hs0, 12);
        chk("t1_done_pulses", done_cnt - dc0, 1);
        if (hs_total - hs0 >= 12)
            chk("t1_consecutive", hs_cyc[hs0 + 11] - hs_cyc[hs0], 11);

        // Same grid, random backpressure.
        ready_mode = 1;
        hs0 = hs_total; dc0 = done_cnt;
        start_scan(0);
        wait_done(300, n);
        chk("t2_point_count", point_count, 12);
        chk("t2_entries", hs_total - hs0, 12);
        chk("t2_done_pulses", done_cnt - dc0, 1);

        // Three ground cells dropped.
        grid_three_ground();
        hs0 = hs_total;
        start_scan(1);
        wait_done(300, n);
        chk("t3_point_count", point_count, 9);
        chk("t3_entries", hs_total - hs0, 9);

        // All ground, skipping: no output, done still pulses.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) gnd[r][c] = 1'b1;
        vc0 = valid_cycles; dc0 = done_cnt;
        start_scan(1);
        wait_done(60, n);
        chk("t4_no_valid", valid_cycles - vc0, 0);
        chk("t4_point_count", point_count, 0);
        chk("t4_done_pulses", done_cnt - dc0, 1);
        chk("t4_done_timing", (n >= 12 && n <= 20), 1);

        // Second start mid-scan is ignored (its skip request included).
        grid_three_ground();
        hs0 = hs_total;
        start_scan(0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        skip_ground = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(300, n);
        chk("t5_entries", hs_total - hs0, 12);
        chk("t5_point_count", point_count, 12);
        hs0 = hs_total;
        start_scan(1);
        @(negedge clk);
        chk("t5_restart_count", point_count, 0);
        wait_done(300, n);
        chk("t5_second_entries", hs_total - hs0, 9);

        // Reset after five entries, then a clean scan.
        grid_plain();
        hs0 = hs_total;
        start_scan(0);
        n = 0;
        while (hs_total - hs0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reached_five", hs_total - hs0 >= 5, 1);
        dc0 = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset("t6_async");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_done", done_cnt - dc0, 0);
        hs0 = hs_total;
        start_scan(0);
        wait_done(300, n);
        chk("t6_entries", hs_total - hs0, 12);
        chk("t6_point_count", point_count, 12);

        // Randomised grids, skip mode and backpressure.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    lbl[r][c] = int'($urandom % 65536);
                    gnd[r][c] = (($urandom % 4) == 0);
                end
            skip = 1'($urandom % 2);
            hs0 = hs_total; dc0 = done_cnt;
            start_scan(skip);
            wait_done(300, n);
            chk("rand_entries", hs_total - hs0, exp_n);
            chk("rand_done_pulses", done_cnt - dc0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fcc_point_scanner.md
Name: fcc_point_scanner

Overview:
- Read-side sequencer for fcc_point_memory: raster-scans every (row,col) cell and streams out (row, col, label) over a valid/ready interface.
- Drives the memory's synchronous read port (1-cycle registered read latency) and absorbs downstream backpressure with a 2-entry buffer, losing and duplicating nothing.
- Optionally drops ground cells.
- Sits between the labelling stage (the memory writer) and the cluster statistics/export logic.

Parameters:
- ROWS, 30, grid rows.
- COLS, 30, grid columns.
- ROW_W, 8, row index width.
- COL_W, 5, column index width.
- LABEL_W, 16, label width.
- CNT_W, 16, emitted-point counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a scan when idle.
- skip_ground  in  1  sampled with start; 1 = discard cells with is_ground=1.
- busy  out  1  high from accepted start until done.
- done  out  1  1-cycle pulse at scan completion.
- point_count  out  CNT_W  points emitted in the current/last scan.
- rd_row  out  ROW_W  memory read row (registered).
- rd_col  out  COL_W  memory read column (registered).
- rd_label  in  LABEL_W  memory read data; valid 1 cycle after address.
- rd_is_ground  in  1  memory ground flag; same timing as rd_label.
- out_valid  out  1  stream entry valid.
- out_ready  in  1  downstream accept.
- out_row  out  ROW_W  entry row.
- out_col  out  COL_W  entry column.
- out_label  out  LABEL_W  entry label.

Behaviour:
- Reset values: busy=0, done=0, point_count=0, rd_row=0, rd_col=0, out_valid=0, out_row/out_col/out_label=0. Buffer and in-flight flag are cleared.
- Reset mid-scan aborts immediately; no done pulse.
- States:
  - IDLE: start=1 latches skip_ground, clears point_count, sets busy → SCAN.
  - SCAN: issues addresses in raster order (col fastest; (0,0) … (ROWS-1,COLS-1)); last address issued → DRAIN.
  - DRAIN: waits for in-flight=0 and buffer empty → done=1 for one cycle, busy=0 → IDLE.
- start while busy is ignored. start and done in the same cycle: done is reported, the start is ignored.
- Issue rule: an address is issued in cycle t only if buf_count + inflight − pop_t < 2, where pop_t = out_valid && out_ready. The issued address is placed on rd_row/rd_col at the next edge and sets inflight=1.
- Capture: one cycle after issue, rd_label/rd_is_ground are paired with the tag (row,col) of the issued address.
  - Enqueued unless skip_ground=1 and rd_is_ground=1; a discarded entry only clears inflight.
- Buffer: 2-entry FIFO, in order. out_* shows the head entry; out_valid = buf_count≠0.
  - Head is held stable while out_valid && !out_ready.
  - Push and pop in the same cycle are allowed.
- Throughput: with out_ready held at 1 and no skipping, 1 point/cycle in steady state.
- Latency: first out_valid rises 3 edges after the start sampling edge (issue edge, memory read edge, buffer write edge).
- point_count increments on each handshake and saturates at 2^CNT_W−1. It holds its value after done until the next accepted start.
- Row/col wrap: col==COLS-1 → col=0, row+1. Last cell is row==ROWS-1 && col==COLS-1. Index compare uses the full ROW_W/COL_W width.
- Integration requirement: the memory is not written while busy=1. Behaviour under concurrent writes is unspecified.
- All-ground grid with skip_ground=1: out_valid never rises; done still pulses; point_count=0.

Test Plan:
- ROWS=3, COLS=4, labels = 10·r+c, no ground, out_ready=1 → 12 entries in raster order (0,0,0)…(2,3,23) on consecutive cycles; done pulses once; point_count=12.
- Same grid, out_ready toggling 1,0,0,1,… (pseudo-random 50%) → identical 12-entry sequence with no loss or duplication; out_* stable whenever valid && !ready.
- Cells (0,1), (1,2), (2,3) ground, skip_ground=1 → 9 entries with those three omitted; point_count=9; done pulses after the final handshake.
- All cells ground, skip_ground=1 → no out_valid; done pulses about 14 cycles after start; point_count=0.
- Second start pulse mid-scan → ignored, exactly 12 entries emitted. Start after done → new scan, point_count restarts at 0.
- Assert rst after 5 entries → all outputs return to reset values asynchronously; a subsequent start gives a clean full 12-entry scan.
